// File: rtl/pool_window_fetch_pkg.sv
// Shared types and constants for the 2x2 pooling window fetcher.
// DATA_BITS is the pixel width shared by the design and the bench.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

package pool_window_fetch_pkg;

  // Slot codes driven on pix_cnt toward the pooling stage
  localparam logic [3:0] POOL_SLOT_LAST  = 4'd3;
  localparam logic [3:0] POOL_SLOT_FLUSH = 4'd4;
  localparam logic [3:0] POOL_SLOT_IDLE  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // One pipeline slot: valid marks a pixel or flush slot, read marks a memory fetch
  typedef struct packed {
    logic       valid;
    logic       read;
    logic [2:0] phase;
  } slot_t;

  // Counter width for n states, never narrower than one bit
  function automatic int unsigned bits_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_window_fetch_addr_gen.sv
// Window row/column and phase counters plus source/pooled address arithmetic.
module pool_addr_gen
  import pool_window_fetch_pkg::*;
#(
  parameter int unsigned IMG_W          = 64,
  parameter int unsigned IMG_H          = 64,
  parameter int unsigned ADDR_BITS      = 12,
  parameter int unsigned POOL_ADDR_BITS = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      adv,
  output logic [2:0]                phase,
  output logic [ADDR_BITS-1:0]      rd_addr_c,
  output logic [POOL_ADDR_BITS-1:0] win_addr_c,
  output logic                      last_win_c
);

  localparam int unsigned COLS     = IMG_W / 2;
  localparam int unsigned ROWS     = IMG_H / 2;
  localparam int unsigned COL_BITS = bits_for(COLS);
  localparam int unsigned ROW_BITS = bits_for(ROWS);

  logic [COL_BITS-1:0]  col;
  logic [ROW_BITS-1:0]  row;
  logic                 col_wrap;
  logic                 row_wrap;
  logic [ADDR_BITS-1:0] src_row;
  logic [ADDR_BITS-1:0] src_col;

  assign col_wrap   = (col == COL_BITS'(COLS - 1));
  assign row_wrap   = (row == ROW_BITS'(ROWS - 1));
  assign last_win_c = col_wrap & row_wrap;

  // Source pixel: row 2r+(p>>1), column 2c+(p&1)
  assign src_row    = ADDR_BITS'({row, phase[1]});
  assign src_col    = ADDR_BITS'({col, phase[0]});
  assign rd_addr_c  = src_row * ADDR_BITS'(IMG_W) + src_col;
  assign win_addr_c = POOL_ADDR_BITS'(row) * POOL_ADDR_BITS'(COLS) + POOL_ADDR_BITS'(col);

  // Step phase 0..4, then move to the next window in raster order (wraps to 0 after the last)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      col   <= '0;
      row   <= '0;
    end else if (clk_en && adv) begin
      if (phase == 3'(POOL_SLOT_FLUSH)) begin
        phase <= '0;
        if (col_wrap) begin
          col <= '0;
          row <= row_wrap ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        phase <= phase + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pool_window_fetch.sv
// Feeder for the 2x2 max-pool stage: walks the feature map window by window,
// presents four pixels and a flush slot per window, pulses done at the end.
// Optional: define POOL_FETCH_RELU_EN to clamp negative read data to zero.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module pool_window_fetch
  import pool_window_fetch_pkg::*;
#(
  parameter int unsigned IMG_W          = 64,
  parameter int unsigned IMG_H          = 64,
  parameter int unsigned ADDR_BITS      = 12,
  parameter int unsigned POOL_ADDR_BITS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_BITS-1:0]         mem_rd_addr,
  input  logic signed [`DATA_BITS-1:0] mem_rd_data,
  output logic signed [`DATA_BITS-1:0] pix_out,
  output logic [3:0]                   pix_cnt,
  output logic [POOL_ADDR_BITS-1:0]    pool_addr
);

  state_t                       state;
  state_t                       state_nxt;
  logic                         load_issue;
  logic                         accept;
  logic                         pass_end;

  logic [2:0]                   gen_phase;
  logic [ADDR_BITS-1:0]         gen_addr;
  logic [POOL_ADDR_BITS-1:0]    gen_win;
  logic                         gen_last;

  slot_t                        iss;
  logic [POOL_ADDR_BITS-1:0]    iss_win;
  slot_t                        s2;
  logic [POOL_ADDR_BITS-1:0]    s2_win;

  logic                         rd_pend;
  logic                         hold_valid;
  logic signed [`DATA_BITS-1:0] hold_data;
  logic signed [`DATA_BITS-1:0] pix_src;
  logic signed [`DATA_BITS-1:0] pix_val;

  pool_addr_gen #(
    .IMG_W          (IMG_W),
    .IMG_H          (IMG_H),
    .ADDR_BITS      (ADDR_BITS),
    .POOL_ADDR_BITS (POOL_ADDR_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .adv        (load_issue),
    .phase      (gen_phase),
    .rd_addr_c  (gen_addr),
    .win_addr_c (gen_win),
    .last_win_c (gen_last)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  // FSM next state: FINISH once the last window's final read is issued
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN:    if (gen_last && gen_phase == 3'(POOL_SLOT_LAST)) state_nxt = ST_FINISH;
      ST_FINISH: if (pix_cnt == POOL_SLOT_FLUSH) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM controls: which slot enters the issue stage, pass start and end
  always_comb begin
    load_issue = 1'b0;
    accept     = 1'b0;
    pass_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        accept     = start;
        load_issue = start;
      end
      ST_RUN: begin
        load_issue = 1'b1;
      end
      ST_FINISH: begin
        load_issue = (gen_phase == 3'(POOL_SLOT_FLUSH));
        pass_end   = (pix_cnt == POOL_SLOT_FLUSH);
      end
      default: begin
        load_issue = 1'b0;
      end
    endcase
  end

  // No read may reach memory while the pipeline is stalled
  assign mem_rd_en = iss.read & clk_en;

  // Issue stage: registered read strobe/address and slot tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss         <= '0;
      iss_win     <= '0;
      mem_rd_addr <= '0;
    end else if (clk_en) begin
      iss.valid <= load_issue;
      iss.read  <= load_issue && (gen_phase != 3'(POOL_SLOT_FLUSH));
      iss.phase <= gen_phase;
      iss_win   <= gen_win;
      if (load_issue && (gen_phase != 3'(POOL_SLOT_FLUSH))) begin
        mem_rd_addr <= gen_addr;
      end
    end
  end

  // Data stage: slot whose read data is on the bus this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2     <= '0;
      s2_win <= '0;
    end else if (clk_en) begin
      s2     <= iss;
      s2_win <= iss_win;
    end
  end

  // Catch read data that returns while stalled so it is presented later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend    <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      rd_pend <= mem_rd_en;
      if (clk_en) begin
        hold_valid <= 1'b0;
      end else if (rd_pend) begin
        hold_valid <= 1'b1;
        hold_data  <= mem_rd_data;
      end
    end
  end

  assign pix_src = hold_valid ? hold_data : mem_rd_data;

  // Optional ReLU clamp on the pixel path
  always_comb begin
`ifdef POOL_FETCH_RELU_EN
    pix_val = pix_src[`DATA_BITS-1] ? '0 : pix_src;
`else
    pix_val = pix_src;
`endif
  end

  // Presentation stage: pixel slots, flush slot with pooled address, idle otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_out   <= '0;
      pix_cnt   <= POOL_SLOT_IDLE;
      pool_addr <= '0;
    end else if (clk_en) begin
      if (s2.valid && s2.read) begin
        pix_out <= pix_val;
        pix_cnt <= 4'(s2.phase);
      end else if (s2.valid) begin
        pix_cnt   <= POOL_SLOT_FLUSH;
        pool_addr <= s2_win;
      end else begin
        pix_cnt <= POOL_SLOT_IDLE;
      end
    end
  end

  // Pass status: busy from accepted start until done, done pulses after last flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (clk_en) begin
      done <= pass_end;
      if (accept) begin
        busy <= 1'b1;
      end else if (pass_end) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_fetch.sv
// Scoreboard bench for pool_window_fetch: expected reads and slots are built
// from a memory model at start and consumed as the DUT produces them.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module tb_pool_window_fetch;

  localparam int IMG_W     = 64;
  localparam int IMG_H     = 64;
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int NWIN      = NPIX / 4;
  localparam int DW        = `DATA_BITS;
  localparam int CYC_LIMIT = 20000;

  typedef struct {
    int cnt;
    int pix;
    int paddr;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clk_en;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 mem_rd_en;
  logic [11:0]          mem_rd_addr;
  logic signed [DW-1:0] mem_rd_data = '0;
  logic signed [DW-1:0] pix_out;
  logic [3:0]           pix_cnt;
  logic [9:0]           pool_addr;

  logic signed [DW-1:0] mem [NPIX];
  exp_t                 exp_q[$];
  int                   exp_addr[$];
  int                   n_checks = 0;
  int                   n_fail = 0;
  int                   done_cnt = 0;
  int                   flush_cnt = 0;
  bit                   mon_on = 1'b0;
  bit                   m_en;
  bit                   m_rd;
  int                   m_addr;
  exp_t                 m_e;

  pool_window_fetch #(
    .IMG_W          (64),
    .IMG_H          (64),
    .ADDR_BITS      (12),
    .POOL_ADDR_BITS (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pix_out     (pix_out),
    .pix_cnt     (pix_cnt),
    .pool_addr   (pool_addr)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after a read, junk otherwise
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= DW'(32'sh5A5A);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic build_expect();
    int a;
    int v;
    int last;
    exp_q.delete();
    exp_addr.delete();
    last = 0;
    for (int r = 0; r < IMG_H / 2; r++) begin
      for (int c = 0; c < IMG_W / 2; c++) begin
        for (int p = 0; p < 4; p++) begin
          a = (2 * r + p / 2) * IMG_W + 2 * c + (p % 2);
          exp_addr.push_back(a);
          v = int'(mem[a]);
`ifdef POOL_FETCH_RELU_EN
          if (v < 0) v = 0;
`endif
          last = v;
          exp_q.push_back('{p, v, 0});
        end
        exp_q.push_back('{4, last, r * (IMG_W / 2) + c});
      end
    end
  endtask

  task automatic rst_checks(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_rd_en"}, mem_rd_en, 0);
    check({pfx, "_rd_addr"}, mem_rd_addr, 0);
    check({pfx, "_pix_out"}, pix_out, 0);
    check({pfx, "_pix_cnt"}, pix_cnt, 15);
    check({pfx, "_pool_addr"}, pool_addr, 0);
  endtask

  // Monitor: compare every real read and every presented slot against the queues
  always @(posedge clk) begin
    m_en   = clk_en;
    m_rd   = mem_rd_en;
    m_addr = int'(mem_rd_addr);
    #1;
    if (mon_on && reset) begin
      if (m_rd) begin
        if (exp_addr.size() == 0) check("rd_addr_extra", m_addr, -1);
        else                      check("rd_addr", m_addr, exp_addr.pop_front());
      end
      if (m_en && pix_cnt != 4'd15) begin
        if (exp_q.size() == 0) begin
          check("pix_extra", int'(pix_cnt), -1);
        end else begin
          m_e = exp_q.pop_front();
          check("pix_cnt", pix_cnt, m_e.cnt);
          check("pix_out", pix_out, m_e.pix);
          if (m_e.cnt == 4) begin
            check("pool_addr", pool_addr, m_e.paddr);
            flush_cnt++;
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_pass(input bit second_start, input bit stall65, input bit rnd_stall,
                          input int abort_win, input int exp_cycles);
    int cyc;
    int stall_left;
    bit seen65;
    bit finished;
    build_expect();
    done_cnt  = 0;
    flush_cnt = 0;
    mon_on    = 1'b1;
    @(negedge clk);
    clk_en = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc        = 0;
    stall_left = 0;
    seen65     = 1'b0;
    finished   = 1'b0;
    while (!finished && cyc < CYC_LIMIT) begin
      if (stall_left > 0) begin
        clk_en = 1'b0;
        stall_left--;
      end else if (rnd_stall) begin
        clk_en = ($urandom_range(0, 3) != 0);
      end else begin
        clk_en = 1'b1;
      end
      start = second_start && (cyc == 100);
      if (stall65 && !seen65 && clk_en && mem_rd_addr == 12'd65) begin
        seen65     = 1'b1;
        stall_left = 3;
      end
      @(posedge clk);
      #2;
      cyc++;
      if (abort_win > 0 && flush_cnt >= abort_win) begin
        reset = 1'b0;
        #1;
        rst_checks("abort");
        mon_on = 1'b0;
        exp_q.delete();
        exp_addr.delete();
        start  = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("abort_no_done", done_cnt, 0);
        check("abort_hold_pix_cnt", pix_cnt, 15);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (done) finished = 1'b1;
    end
    start = 1'b0;
    check("pass_done_seen", finished, 1);
    if (exp_cycles > 0) check("pass_cycles", cyc, exp_cycles);
    check("done_busy_low", busy, 0);
    check("done_pix_cnt", pix_cnt, 15);
    clk_en = 1'b1;
    @(posedge clk);
    #2;
    check("done_one_cycle", done, 0);
    check("done_pulses", done_cnt, 1);
    check("exp_pix_left", exp_q.size(), 0);
    check("exp_addr_left", exp_addr.size(), 0);
    mon_on = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = DW'(i);

    repeat (3) @(posedge clk);
    #2;
    rst_checks("rst");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      check("idle_pix_cnt", pix_cnt, 15);
      check("idle_busy", busy, 0);
      check("idle_rd_en", mem_rd_en, 0);
    end

    // Full pass, identity memory, extra start mid-pass must be ignored
    run_pass(1'b1, 1'b0, 1'b0, 0, 5 * NWIN + 2);
    check("last_pool_addr", pool_addr, NWIN - 1);

    // Negative pixel, stall right after the read of 65, reset at window 10
    mem[1] = DW'(-7);
    run_pass(1'b0, 1'b1, 1'b0, 10, 0);
    @(posedge clk);
    #2;
    check("post_abort_pix_cnt", pix_cnt, 15);
    check("post_abort_busy", busy, 0);

    // Restart after abort with random data and random stalls
    for (int i = 0; i < NPIX; i++) mem[i] = DW'($urandom);
    mem[1] = DW'(-7);
    run_pass(1'b0, 1'b0, 1'b1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
